instr_encoder: RTL and testbench

Encodes decoded LC-3b instruction fields back into 16-bit instruction words and writes them sequentially to memory. It is the write-side counterpart of the instruction register's field decode. Loaders, test harnesses and the debug monitor use it to place instruction streams into memory through the standard `mem_*` handshake. It holds a 2-entry encoded-word FIFO in front of a memory-write state machine with an auto-incrementing byte address.

---
 rtl/instr_encoder_pkg.sv | 47 ++++
 rtl/instr_encoder_fifo.sv | 57 +++++
 rtl/instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared LC-3b field types and the instr_encoder FSM state encoding.
// The READBACK state is present only when INSTR_ENCODER_READBACK_EN is defined.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [4:0]  lc3b_imm5;
  typedef logic [10:0] lc3b_imm11;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef enum logic [1:0] {
`ifdef INSTR_ENCODER_READBACK_EN
    S_READBACK = 2'd2,
`endif
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1
  } instr_encoder_state;

  localparam lc3b_word ADDR_STEP  = 16'd2;
  localparam lc3b_word COUNT_STEP = 16'd1;

  // Instruction words are 16-bit aligned in a byte-addressed memory.
  function automatic lc3b_word word_align(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Small encoded-word FIFO sitting between the encoder and the memory-write FSM.
// Pointers wrap by natural overflow, so DEPTH must be a power of two (only 2 is used).
module instr_encoder_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  logic     pop_i,
  input  lc3b_word wdata_i,
  output lc3b_word rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = DEPTH;

  lc3b_word      mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// LC-3b field-tuple encoder feeding a sequential memory-write FSM via a 2-entry FIFO.
// Define INSTR_ENCODER_READBACK_EN to add a read-back verify pass after every write.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for the FIFO to hold a word; addr_load honoured here
// WRITE    | mem_write asserted with FIFO head at addr until mem_resp
// READBACK | mem_read at same addr until mem_resp, then compare to head
module instr_encoder
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_load,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  dest,
  input  logic [2:0]  src1,
  input  logic [2:0]  src2,
  input  logic [5:0]  offset6,
  input  logic [8:0]  offset9,
  input  logic [10:0] imm11,
  input  logic [4:0]  imm5,
  input  logic        imm5_enable,
  input  logic        imm11_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy,
  output logic [15:0] count,
  output logic        verify_error
);

  instr_encoder_state state_q;
  lc3b_word           addr_q;
  lc3b_word           count_q;
  lc3b_word           wdata_q;
  logic               mem_write_q;
  lc3b_opcode         op;
  lc3b_word           enc_word;
  lc3b_word           head;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  assign op = lc3b_opcode'(opcode);

  always_comb begin
    enc_word = '0;
    case (op)
      op_add, op_and:
        enc_word = imm5_enable ? {opcode, dest, src1, 1'b1, imm5}
                               : {opcode, dest, src1, 3'b000, src2};
      op_not:
        enc_word = {opcode, dest, src1, 6'h3f};
      op_br, op_lea:
        enc_word = {opcode, dest, offset9};
      op_jmp:
        enc_word = {opcode, 3'b000, src1, 6'h00};
      op_jsr:
        enc_word = imm11_enable ? {opcode, 1'b1, imm11}
                                : {opcode, 3'b000, src1, 6'h00};
      op_ldb, op_ldr, op_ldi, op_stb, op_str, op_sti, op_shf:
        enc_word = {opcode, dest, src1, offset6};
      op_trap:
        enc_word = {opcode, 4'h0, offset9[7:0]};
      op_rti:
        enc_word = {opcode, 12'h000};
      default:
        enc_word = '0;
    endcase
  end

  assign push = in_valid && in_ready;

  instr_encoder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (enc_word),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full is a flop-derived count, so in_ready never depends on in_valid.
  assign in_ready        = !fifo_full;
  assign busy            = (state_q != S_IDLE) || !fifo_empty;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = 2'b11;
  assign count           = count_q;

`ifdef INSTR_ENCODER_READBACK_EN
  logic mem_read_q;
  logic verify_error_q;

  assign pop          = (state_q == S_READBACK) && mem_resp;
  assign mem_read     = mem_read_q;
  assign verify_error = verify_error_q;
`else
  logic unused_rdata;

  assign pop          = (state_q == S_WRITE) && mem_resp;
  assign mem_read     = 1'b0;
  assign verify_error = 1'b0;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      count_q        <= '0;
      wdata_q        <= '0;
      mem_write_q    <= 1'b0;
`ifdef INSTR_ENCODER_READBACK_EN
      mem_read_q     <= 1'b0;
      verify_error_q <= 1'b0;
`endif
    end else begin
      if (pop) begin
        addr_q  <= addr_q + ADDR_STEP;
        count_q <= count_q + COUNT_STEP;
      end
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q     <= S_WRITE;
            mem_write_q <= 1'b1;
            wdata_q     <= head;
          end else if (addr_load) begin
            addr_q         <= word_align(base_addr);
            count_q        <= '0;
`ifdef INSTR_ENCODER_READBACK_EN
            verify_error_q <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (mem_resp) begin
            mem_write_q <= 1'b0;
`ifdef INSTR_ENCODER_READBACK_EN
            state_q     <= S_READBACK;
            mem_read_q  <= 1'b1;
`else
            state_q     <= S_IDLE;
`endif
          end
        end
`ifdef INSTR_ENCODER_READBACK_EN
        S_READBACK: begin
          if (mem_resp) begin
            mem_read_q <= 1'b0;
            state_q    <= S_IDLE;
            if (mem_rdata != head) verify_error_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with a latency-programmable memory responder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        addr_load = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  dest = '0, src1 = '0, src2 = '0;
  logic [5:0]  offset6 = '0;
  logic [8:0]  offset9 = '0;
  logic [10:0] imm11 = '0;
  logic [4:0]  imm5 = '0;
  logic        imm5_enable = 1'b0, imm11_enable = 1'b0;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic        busy, verify_error;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  logic rb_corrupt = 1'b0;
  logic spurious = 1'b0;
  logic saw_not_ready = 1'b0;
  logic [15:0] last_w = '0;
  logic [31:0] wr_log[$];
  int rd_cycles = 0, wr_cycles = 0, both_cycles = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .addr_load(addr_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .dest(dest),
    .src1(src1), .src2(src2), .offset6(offset6), .offset9(offset9),
    .imm11(imm11), .imm5(imm5), .imm5_enable(imm5_enable), .imm11_enable(imm11_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy), .count(count), .verify_error(verify_error)
  );

  // Memory model: answers a write or read after lat idle cycles, logs every write.
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = spurious;
      if (mem_read) rd_cycles++;
      if (mem_write) wr_cycles++;
      if (mem_read && mem_write) both_cycles++;
      if (!in_ready) saw_not_ready = 1'b1;
      if (mem_write || mem_read) begin
        if (cnt >= lat) begin
          mem_resp = 1'b1;
          cnt = 0;
          if (mem_write) begin
            wr_log.push_back({mem_address, mem_wdata});
            last_w = mem_wdata;
          end else begin
            mem_rdata = rb_corrupt ? 16'h0000 : last_w;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    in_valid = 1'b0;
    addr_load = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_addr(input logic [15:0] a);
    @(negedge clk);
    base_addr = a;
    addr_load = 1'b1;
    @(posedge clk);
    #1 addr_load = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [5:0] o6, input logic [8:0] o9,
                      input logic [10:0] i11, input logic [4:0] i5, input logic i5e,
                      input logic i11e);
    int n;
    n = 0;
    @(negedge clk);
    opcode = op; dest = d; src1 = s1; src2 = s2; offset6 = o6; offset9 = o9;
    imm11 = i11; imm5 = i5; imm5_enable = i5e; imm11_enable = i11e;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL send_accept in_ready stuck low got=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL wait_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic wait_write();
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_write mem_write got=%b exp=1", mem_write);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
    checks++; if (mem_address !== 16'h0000) begin failures++; $display("FAIL rst_mem_address got=%h exp=0000", mem_address); end
    checks++; if (mem_wdata !== 16'h0000) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0000", mem_wdata); end
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL rst_count got=%h exp=0000", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (verify_error !== 1'b0) begin failures++; $display("FAIL rst_verify_error got=%b exp=0", verify_error); end
    checks++; if (mem_byte_enable !== 2'b11) begin failures++; $display("FAIL rst_byte_enable got=%b exp=11", mem_byte_enable); end
  endtask

  task automatic test_add();
    do_reset();
    load_addr(16'h3000);
    lat = 1;
    wr_log.delete();
    send(4'h1, 3'd1, 3'd2, 3'd0, 6'h00, 9'h000, 11'h000, 5'h1d, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL add_idle_cycle mem_write got=%b exp=0", mem_write); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL add_write_start got=%b exp=1", mem_write); end
    checks++; if (mem_address !== 16'h3000) begin failures++; $display("FAIL add_address got=%h exp=3000", mem_address); end
    checks++; if (mem_wdata !== 16'h12bd) begin failures++; $display("FAIL add_wdata got=%h exp=12bd", mem_wdata); end
    wait_idle();
    checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL add_nwrites got=%0d exp=1", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 32'h3000_12bd) begin failures++; $display("FAIL add_log got=%h exp=300012bd", wr_log[0]); end
    end
    checks++; if (count !== 16'd1) begin failures++; $display("FAIL add_count got=%h exp=0001", count); end
  endtask

  task automatic test_encodings();
    logic [3:0]  t_op  [9] = '{4'h1, 4'h8, 4'he, 4'hc, 4'h4, 4'h2, 4'hd, 4'hf, 4'h5};
    logic [2:0]  t_d   [9] = '{3'd5, 3'd7, 3'd2, 3'd5, 3'd6, 3'd1, 3'd3, 3'd7, 3'd0};
    logic [2:0]  t_s1  [9] = '{3'd6, 3'd7, 3'd4, 3'd7, 3'd3, 3'd2, 3'd3, 3'd7, 3'd1};
    logic [2:0]  t_s2  [9] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd2};
    logic [5:0]  t_o6  [9] = '{6'h00, 6'h3f, 6'h00, 6'h3f, 6'h3f, 6'h2a, 6'h11, 6'h3f, 6'h00};
    logic [8:0]  t_o9  [9] = '{9'h000, 9'h1ff, 9'h1a0, 9'h1ff, 9'h000, 9'h000, 9'h000, 9'h1ff, 9'h000};
    logic [10:0] t_i11 [9] = '{11'h000, 11'h7ff, 11'h000, 11'h000, 11'h7ff, 11'h000, 11'h000, 11'h000, 11'h000};
    logic [4:0]  t_i5  [9] = '{5'h1f, 5'h1f, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h15};
    logic [15:0] t_exp [9] = '{16'h1b87, 16'h8000, 16'he5a0, 16'hc1c0, 16'h40c0,
                               16'h22aa, 16'hd6d1, 16'hf0ff, 16'h5042};
    logic [31:0] want;
    do_reset();
    load_addr(16'h3000);
    lat = 0;
    wr_log.delete();
    for (int i = 0; i < 9; i++) begin
      send(t_op[i], t_d[i], t_s1[i], t_s2[i], t_o6[i], t_o9[i], t_i11[i], t_i5[i], 1'b0, 1'b0);
      wait_idle();
      want = {16'h3000 + 16'(2 * i), t_exp[i]};
      checks++;
      if (wr_log.size() != i + 1) begin
        failures++;
        $display("FAIL enc_nwrites[%0d] got=%0d exp=%0d", i, wr_log.size(), i + 1);
      end else if (wr_log[i] !== want) begin
        failures++;
        $display("FAIL enc_word[%0d] got=%h exp=%h", i, wr_log[i], want);
      end
    end
    checks++; if (count !== 16'd9) begin failures++; $display("FAIL enc_count got=%h exp=0009", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_log [4] = '{32'h3000_973f, 32'h3002_05ff, 32'h3004_4805, 32'h3006_f025};
    do_reset();
    load_addr(16'h3000);
    lat = 3;
    wr_log.delete();
    saw_not_ready = 1'b0;
    send(4'h9, 3'd3, 3'd4, 3'd0, 6'h00, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    send(4'h0, 3'b010, 3'd0, 3'd0, 6'h00, 9'h1ff, 11'h000, 5'h00, 1'b0, 1'b0);
    send(4'h4, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 11'h005, 5'h00, 1'b0, 1'b1);
    send(4'hf, 3'd0, 3'd0, 3'd0, 6'h00, 9'h025, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_idle();
    checks++; if (saw_not_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_low got=%b exp=1", saw_not_ready); end
    checks++; if (wr_log.size() != 4) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=4", wr_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_log[i] !== exp_log[i]) begin
          failures++;
          $display("FAIL b2b_word[%0d] got=%h exp=%h", i, wr_log[i], exp_log[i]);
        end
      end
    end
    checks++; if (count !== 16'd4) begin failures++; $display("FAIL b2b_count got=%h exp=0004", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_end got=%b exp=1", in_ready); end
  endtask

  task automatic test_wrap_and_spurious();
    do_reset();
    load_addr(16'hffff);
    lat = 0;
    wr_log.delete();
    send(4'h7, 3'd1, 3'd2, 3'd0, 6'h05, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    send(4'h7, 3'd3, 3'd4, 3'd0, 6'h3f, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_idle();
    checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL wrap_nwrites got=%0d exp=2", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 32'hfffe_7285) begin failures++; $display("FAIL wrap_first got=%h exp=fffe7285", wr_log[0]); end
      checks++; if (wr_log[1] !== 32'h0000_773f) begin failures++; $display("FAIL wrap_second got=%h exp=0000773f", wr_log[1]); end
    end
    @(negedge clk);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    @(negedge clk);
    checks++; if (count !== 16'd2) begin failures++; $display("FAIL spur_count got=%h exp=0002", count); end
    checks++; if (mem_address !== 16'h0002) begin failures++; $display("FAIL spur_address got=%h exp=0002", mem_address); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset();
    load_addr(16'h3000);
    lat = 10;
    wr_log.delete();
    send(4'h6, 3'd0, 3'd1, 3'd0, 6'h01, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    send(4'h9, 3'd3, 3'd4, 3'd0, 6'h00, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_write();
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rstmid_mem_write got=%b exp=0", mem_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL rstmid_count got=%h exp=0000", count); end
    checks++; if (mem_address !== 16'h0000) begin failures++; $display("FAIL rstmid_address got=%h exp=0000", mem_address); end
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cycles;
    repeat (30) @(negedge clk);
    checks++; if (wr_cycles != w0) begin failures++; $display("FAIL rstmid_no_writes got=%0d exp=%0d", wr_cycles, w0); end
    checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL rstmid_nlog got=%0d exp=0", wr_log.size()); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    lat = 0;
  endtask

  task automatic test_addr_load_busy();
    do_reset();
    load_addr(16'h3000);
    lat = 3;
    wr_log.delete();
    send(4'h1, 3'd1, 3'd2, 3'd0, 6'h00, 9'h000, 11'h000, 5'h1d, 1'b1, 1'b0);
    wait_write();
    load_addr(16'h5000);
    wait_idle();
    send(4'h9, 3'd3, 3'd4, 3'd0, 6'h00, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_idle();
    checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL aload_nwrites got=%0d exp=2", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 32'h3000_12bd) begin failures++; $display("FAIL aload_first got=%h exp=300012bd", wr_log[0]); end
      checks++; if (wr_log[1] !== 32'h3002_973f) begin failures++; $display("FAIL aload_ignored got=%h exp=3002973f", wr_log[1]); end
    end
    checks++; if (count !== 16'd2) begin failures++; $display("FAIL aload_count_before got=%h exp=0002", count); end
    load_addr(16'h4000);
    checks++; if (count !== 16'd0) begin failures++; $display("FAIL aload_count_clear got=%h exp=0000", count); end
    send(4'h8, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_idle();
    checks++; if (wr_log.size() != 3) begin failures++; $display("FAIL aload_nwrites2 got=%0d exp=3", wr_log.size()); end
    else begin
      checks++; if (wr_log[2] !== 32'h4000_8000) begin failures++; $display("FAIL aload_honoured got=%h exp=40008000", wr_log[2]); end
    end
    checks++; if (count !== 16'd1) begin failures++; $display("FAIL aload_count_after got=%h exp=0001", count); end
  endtask

  task automatic test_readback();
    do_reset();
    load_addr(16'h3000);
    lat = 1;
    wr_log.delete();
`ifdef INSTR_ENCODER_READBACK_EN
    rb_corrupt = 1'b0;
    send(4'h1, 3'd1, 3'd2, 3'd0, 6'h00, 9'h000, 11'h000, 5'h1d, 1'b1, 1'b0);
    wait_idle();
    checks++; if (verify_error !== 1'b0) begin failures++; $display("FAIL rb_clean got=%b exp=0", verify_error); end
    checks++; if (rd_cycles == 0) begin failures++; $display("FAIL rb_read_seen got=%0d exp=nonzero", rd_cycles); end
    rb_corrupt = 1'b1;
    send(4'h5, 3'd1, 3'd1, 3'd0, 6'h00, 9'h000, 11'h000, 5'h02, 1'b1, 1'b0);
    wait_idle();
    rb_corrupt = 1'b0;
    checks++; if (verify_error !== 1'b1) begin failures++; $display("FAIL rb_mismatch got=%b exp=1", verify_error); end
    checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL rb_nwrites got=%0d exp=2", wr_log.size()); end
    else begin
      checks++; if (wr_log[1] !== 32'h3002_5262) begin failures++; $display("FAIL rb_word got=%h exp=30025262", wr_log[1]); end
    end
    checks++; if (count !== 16'd2) begin failures++; $display("FAIL rb_count got=%h exp=0002", count); end
    send(4'h9, 3'd3, 3'd4, 3'd0, 6'h00, 9'h000, 11'h000, 5'h00, 1'b0, 1'b0);
    wait_idle();
    checks++; if (verify_error !== 1'b1) begin failures++; $display("FAIL rb_sticky got=%b exp=1", verify_error); end
    load_addr(16'h3000);
    checks++; if (verify_error !== 1'b0) begin failures++; $display("FAIL rb_clear got=%b exp=0", verify_error); end
`else
    rb_corrupt = 1'b1;
    send(4'h5, 3'd1, 3'd1, 3'd0, 6'h00, 9'h000, 11'h000, 5'h02, 1'b1, 1'b0);
    wait_idle();
    rb_corrupt = 1'b0;
    checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL norb_nwrites got=%0d exp=1", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 32'h3000_5262) begin failures++; $display("FAIL norb_word got=%h exp=30005262", wr_log[0]); end
    end
    checks++; if (verify_error !== 1'b0) begin failures++; $display("FAIL norb_verify_error got=%b exp=0", verify_error); end
    checks++; if (rd_cycles != 0) begin failures++; $display("FAIL norb_mem_read got=%0d exp=0", rd_cycles); end
`endif
    checks++; if (both_cycles != 0) begin failures++; $display("FAIL rw_exclusive got=%0d exp=0", both_cycles); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_encodings();
    test_back_to_back();
    test_wrap_and_spurious();
    test_reset_mid();
    test_addr_load_busy();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
